// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detectors.
//   PAT_11011  - default 5-bit pattern
//   OVL_ON/OFF - overlap mode encodings
//   fill_width - width of a fill counter that saturates at pat_w-1
package seq_detect_pkg;

  localparam logic [4:0] PAT_11011 = 5'b11011;
  localparam logic       OVL_ON    = 1'b1;
  localparam logic       OVL_OFF   = 1'b0;

  // $clog2 wrapper, never narrower than one bit.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag.
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   inc   - count one event this cycle
//   clr   - synchronous clear of count and ovf (wins over inc)
//   count - current count, holds at all-ones
//   ovf   - sticky, set when an event arrives while count is all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if (&count_q) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial sequence detector with run-time pattern and overlap mode.
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   din       - serial data bit, MSB of the pattern arrives first
//   din_valid - qualifies din; the detector only advances on qualified bits
//   cfg_load  - strobe: latch cfg_pat/cfg_ovl and restart the search
//   cfg_pat   - new pattern
//   cfg_ovl   - new overlap mode (1 = overlapping)
//   cnt_clr   - synchronous clear of match_cnt and cnt_ovf
//   dout      - combinational match in the cycle the last pattern bit is presented
//   match_q   - dout delayed by one clock
//   match_cnt - saturating match count
//   cnt_ovf   - sticky counter overflow
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(PAT_11011),
  parameter logic             RST_OVL = OVL_ON,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_ovf
);

  localparam int unsigned         FILL_W   = fill_width(PAT_W);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_r;

  logic [PAT_W-1:0]  window;
  logic              full;
  logic              match;

  // The (fill, history) pair is the detector state; fill says how much of
  // the history holds real bits, so no per-pattern state encoding is needed.
  assign window = {hist_q, din};
  assign full   = (fill_q == FILL_MAX);
  assign match  = din_valid & ~cfg_load & full & (window == pat_q);
  assign dout   = match;

  always_comb begin
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load) begin
      pat_d  = cfg_pat;
      ovl_d  = cfg_ovl;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      if (match && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        fill_d = full ? fill_q : fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= RST_PAT;
      ovl_q   <= RST_OVL;
      hist_q  <= '0;
      fill_q  <= '0;
      match_r <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_r <= match;
    end
  end

  assign match_q = match_r;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_cnt),
    .ovf   (cnt_ovf)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: the driver pushes the reference
// model's expected outputs per cycle, a monitor pops and compares them.
module tb_seq_detect_param;

  localparam int unsigned PAT_W   = 5;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pat = '0;
  logic             cfg_ovl = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             dout;
  logic             match_q;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_ovf;

  always #5 clk = ~clk;

  seq_detect_param #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .cfg_ovl   (cfg_ovl),
    .cnt_clr   (cnt_clr),
    .dout      (dout),
    .match_q   (match_q),
    .match_cnt (match_cnt),
    .cnt_ovf   (cnt_ovf)
  );

  typedef struct packed {
    logic             dout;
    logic             mq;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the list of bits seen since the last restart, the
  // pattern, and plain integer match bookkeeping.
  logic [PAT_W-1:0] m_pat;
  logic             m_ovl;
  logic             m_mq;
  logic             m_ovf;
  int               m_cnt;
  logic             bits[$];

  task automatic m_reset();
    m_pat = 5'b11011;
    m_ovl = 1'b1;
    m_mq  = 1'b0;
    m_ovf = 1'b0;
    m_cnt = 0;
    bits.delete();
  endtask

  // Match when the last PAT_W-1 accepted bits followed by d spell the pattern.
  function automatic logic model_match(input logic d);
    logic [PAT_W-1:0] w;
    if (bits.size() < int'(PAT_W) - 1) return 1'b0;
    w = '0;
    for (int i = 0; i < int'(PAT_W) - 1; i++) w = {w[PAT_W-2:0], bits[i]};
    w = {w[PAT_W-2:0], d};
    return w == m_pat;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one clock of inputs (called at posedge+1) and push the expectation.
  task automatic cycle(input logic v, input logic d, input logic ld = 1'b0,
                       input logic [PAT_W-1:0] p = '0, input logic o = 1'b0,
                       input logic clr = 1'b0);
    exp_t e;
    logic m;
    din_valid = v;
    din       = d;
    cfg_load  = ld;
    cfg_pat   = p;
    cfg_ovl   = o;
    cnt_clr   = clr;
    if (!rst) begin
      m_reset();
      e = '0;
    end else begin
      m     = v && !ld && model_match(d);
      e.dout = m;
      e.mq   = m_mq;
      e.cnt  = CNT_W'(m_cnt);
      e.ovf  = m_ovf;
      if (ld) begin
        m_pat = p;
        m_ovl = o;
        bits.delete();
      end else if (v) begin
        if (m && !m_ovl) begin
          bits.delete();
        end else begin
          bits.push_back(d);
          if (bits.size() > int'(PAT_W) - 1) bits.delete(0);
        end
      end
      m_mq = m;
      if (clr) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end else if (m) begin
        if (m_cnt == CNT_MAX) m_ovf = 1'b1;
        else m_cnt++;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Send n bits of seq MSB first, with gap idle cycles (random din) before each.
  task automatic send_bits(input logic [31:0] seq, input int n, input int gap);
    logic [31:0] s;
    s = seq;
    for (int i = n - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'(($urandom)));
      cycle(1'b1, s[i]);
    end
  endtask

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    fork
      begin : driver
        // Valid bits during reset must not produce dout.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        rst = 1'b1;

        // Default pattern, overlapping: matches on bits 4 and 7.
        send_bits(32'b11011011, 8, 0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Same stream non-overlapping; din during the load is discarded.
        cycle(1'b1, 1'b1, 1'b1, 5'b11011, 1'b0);
        send_bits(32'b11011011, 8, 0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Gaps in din_valid are transparent.
        cycle(1'b0, 1'b0, 1'b1, 5'b11011, 1'b1);
        send_bits(32'b11011, 5, 3);

        // 10101 overlapping, then a load with din=1 restarts the search.
        cycle(1'b0, 1'b0, 1'b1, 5'b10101, 1'b1);
        send_bits(32'b1010101, 7, 0);
        cycle(1'b1, 1'b1, 1'b1, 5'b10101, 1'b1);
        send_bits(32'b10101, 5, 0);

        // Saturation: all-ones pattern on all-ones stream, clear on 5th match.
        cycle(1'b0, 1'b0, 1'b1, 5'b11111, 1'b1, 1'b1);
        repeat (8) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Reset mid-pattern clears everything at once; history is lost.
        cycle(1'b0, 1'b0, 1'b1, 5'b11011, 1'b1);
        send_bits(32'b11011, 5, 0);
        send_bits(32'b1101, 4, 0);
        rst = 1'b0;
        cycle(1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b1, 1'b1);
        send_bits(32'b11011, 5, 0);

        // Randomized traffic with occasional reconfiguration and clears.
        for (int n = 0; n < 1500; n++) begin
          if ($urandom_range(0, 99) < 2) begin
            cycle(1'($urandom), 1'($urandom), 1'b1, PAT_W'($urandom), 1'($urandom),
                  1'($urandom_range(0, 9) == 0));
          end else begin
            cycle($urandom_range(0, 99) < 70, 1'($urandom), 1'b0, '0, 1'b0,
                  $urandom_range(0, 99) < 3);
          end
        end
        cycle(1'b0, 1'b0);
      end
      begin : monitor
        exp_t me;
        forever begin
          @(negedge clk);
          if (sb_q.size() > 0) begin
            me = sb_q.pop_front();
            check("dout", 32'(dout), 32'(me.dout));
            check("match_q", 32'(match_q), 32'(me.mq));
            check("match_cnt", 32'(match_cnt), 32'(me.cnt));
            check("cnt_ovf", 32'(cnt_ovf), 32'(me.ovf));
          end
        end
      end
    join_any
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Mealy serial sequence detector. Successor to the fixed 5-bit detectors in the FSM library.
- The pattern length is set at build time. The pattern value and overlap/non-overlap mode are loaded at run time.
- Adds an input qualifier, a registered match pulse, a saturating match counter and a sticky overflow flag.
- Sits on a 1-bit serial stream, one bit per qualified clock. Counter and flags go to status logic.

Parameters:
- PAT_W, 5, pattern length in bits (legal range 2..32).
- RST_PAT, 5'b11011, pattern value after reset. Width PAT_W.
- RST_OVL, 1'b1, overlap mode after reset (1 = overlapping, 0 = non-overlapping).
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  qualifies din. The detector advances only when din_valid=1.
- cfg_load  input  1  one-cycle strobe. Latches cfg_pat and cfg_ovl.
- cfg_pat  input  PAT_W  new pattern. MSB is the first bit received.
- cfg_ovl  input  1  new overlap mode.
- cnt_clr  input  1  synchronous clear of match_cnt and cnt_ovf.
- dout  output  1  Mealy match. Combinational in the cycle the last pattern bit is presented.
- match_q  output  1  registered copy of dout. One-cycle pulse, one clock after dout.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_ovf  output  1  sticky. Set when a match occurs while match_cnt is all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - pat_r=RST_PAT, ovl_r=RST_OVL.
  - Bit history hist_r (PAT_W-1 bits) = 0.
  - Fill counter fill_r = 0.
  - match_q=0, match_cnt=0, cnt_ovf=0.
  - dout=0 while in reset.
- fill_r:
  - Counts qualified bits accepted since the last clear.
  - Saturates at PAT_W-1. Width is $clog2(PAT_W).
- dout (combinational):
  - dout = din_valid & ~cfg_load & (fill_r==PAT_W-1) & ({hist_r,din}==pat_r).
  - Never asserted when din_valid=0.
- Qualified cycle (din_valid=1, cfg_load=0):
  - hist_r <= {hist_r[PAT_W-3:0], din}.
  - If dout=1 and ovl_r=0: hist_r <= 0 and fill_r <= 0 (non-overlapping restart).
  - Otherwise fill_r <= min(fill_r+1, PAT_W-1).
  - Overlapping mode keeps full history, so prefixes and suffixes are reused (e.g. 11011 followed by 011 matches again).
- Idle cycle (din_valid=0): hist_r and fill_r hold. Gaps in din_valid are transparent.
- cfg_load=1:
  - pat_r<=cfg_pat, ovl_r<=cfg_ovl, hist_r<=0, fill_r<=0.
  - Any din presented that cycle is discarded and dout=0.
  - The first qualified bit after the load is bit 0 of a fresh search.
  - match_cnt and cnt_ovf are unaffected.
- match_q <= dout every clock. Latency is 1 cycle after dout.
- Counter (cnt_clr has priority over a simultaneous match):
  - cnt_clr=1: match_cnt<=0, cnt_ovf<=0. A match that cycle is not counted, but dout and match_q still fire.
  - Else if dout=1 and match_cnt != all-ones: match_cnt<=match_cnt+1.
  - Else if dout=1 and match_cnt == all-ones: match_cnt holds, cnt_ovf<=1.
- Reset asserted mid-stream: partial history is lost. After release, a match needs PAT_W fresh qualified bits.
- There is no explicit state encoding. The state is the pair (fill_r, hist_r), equivalent to the classic per-pattern FSM for any pattern value.

Decomposition:
- Package seq_detect_pkg holds:
  - Localparam functions for fill-counter width ($clog2 wrapper).
  - Default pattern constant PAT_11011 = 5'b11011.
  - Mode constants OVL_ON = 1, OVL_OFF = 0.
- One sub-module is natural: sat_counter (CNT_W, inc, clr, count, ovf). It is reusable by the other FSM blocks.
- The history/compare datapath stays in the top module.

Test Plan:
- Reset defaults (11011, overlap), stream 1,1,0,1,1,0,1,1 with din_valid=1 -> dout=1 on bit indices 4 and 7. match_q=1 on cycles 5 and 8. match_cnt=2.
- Same stream after cfg_load with cfg_pat=5'b11011, cfg_ovl=0 -> dout=1 on bit 4 only. match_cnt ends at 1.
- Stream 1,1,0,1,1 with din_valid=0 gaps of 3 cycles between every bit -> exactly one dout pulse, coincident with the final qualified 1. No pulse during the gaps.
- PAT_W=5: cfg_load cfg_pat=5'b10101, overlap, stream 1,0,1,0,1,0,1 -> dout on bits 4 and 6. Then cfg_load asserted together with din=1 -> no dout, and the history restarts.
- CNT_W=2, continuous overlapping matches of pattern 5'b11111 on an all-ones stream -> match_cnt goes 1,2,3 then holds at 3. cnt_ovf sets on the 4th match. cnt_clr concurrent with the 5th match -> match_cnt=0, cnt_ovf=0, and match_q still pulses.
- Assert rst low asynchronously mid-pattern (after 1,1,0,1) -> all outputs are 0 immediately. After release, the remaining bit 1 alone does not match. A full 1,1,0,1,1 is needed.
